// File: rtl/controle_multiplicador_pkg.sv
// controle_multiplicador_pkg: shared FSM encodings and default operand width
package controle_multiplicador_pkg;
  localparam int N_PADRAO = 8;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;
endpackage

// File: rtl/controle_multiplicador_somador.sv
// somador8bits: N-bit ripple-carry adder built from full-adder cells
module somador8bits #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic c;
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/controle_multiplicador.sv
// controle_multiplicador: sequential shift-and-add unsigned multiplier with start/busy/done handshake
module controle_multiplicador
  import controle_multiplicador_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           iniciar,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] produto,
  output logic           ocupado,
  output logic           pronto
);
  localparam int CW = $clog2(N + 1);
  estado_t estado_q, estado_d;
  logic [N-1:0] m_q, m_d, soma;
  logic [2*N:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic cout, carry;
  somador8bits #(.N(N)) u_somador (
    .a    (p_q[2*N-1:N]),
    .b    (m_q),
    .cin  (1'b0),
    .s    (soma),
    .cout (cout)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      m_q      <= m_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
    end
  end
  // the carry is kept in the shifted word so the high half never overflows
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < CW; i++) begin
      cnt_inc[i] = cnt_q[i] ^ carry;
      carry = carry & cnt_q[i];
    end
    estado_d = estado_q;
    m_d = m_q;
    p_d = p_q;
    cnt_d = cnt_q;
    if (estado_q == OCIOSO && iniciar) begin
      m_d = a;
      p_d = {1'b0, {N{1'b0}}, b};
      cnt_d = '0;
      estado_d = CALCULA;
    end else if (estado_q == CALCULA) begin
      p_d = p_q[0] ? {1'b0, cout, soma, p_q[N-1:1]} : p_q >> 1;
      cnt_d = cnt_inc;
      estado_d = (cnt_q == CW'(N - 1)) ? FIM : CALCULA;
    end else if (estado_q == FIM) begin
      estado_d = OCIOSO;
    end
  end
  always_comb begin
    produto = p_q[2*N-1:0];
    ocupado = estado_q != OCIOSO;
    pronto  = estado_q == FIM;
  end
endmodule

// File: tb/tb_controle_multiplicador.sv
// tb_controle_multiplicador: directed checks of the shift-and-add multiplier handshake and results
module tb_controle_multiplicador;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [15:0] produto;
  logic ocupado, pronto;
  int tests = 0;
  int fails = 0;
  controle_multiplicador dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .a       (a),
    .b       (b),
    .produto (produto),
    .ocupado (ocupado),
    .pronto  (pronto)
  );
  always #5 clock = ~clock;
  task automatic start(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask
  // watches one operation from the first CALCULA cycle; scrambles operands and optionally re-pulses iniciar
  task automatic observe(input bit glitch, output int n_occ, output int pr_at, output int pr_cnt,
                         output logic [15:0] val);
    n_occ = 0;
    pr_at = -1;
    pr_cnt = 0;
    val = '0;
    for (int i = 0; i < 14; i++) begin
      if (ocupado) n_occ++;
      if (pronto) begin
        pr_cnt++;
        pr_at = i;
        val = produto;
      end
      if (i == 1) begin
        a = ~a;
        b = b + 8'd37;
      end
      iniciar = glitch && i == 3;
      if (glitch && i == 3) begin
        a = 8'd5;
        b = 8'd7;
      end
      @(negedge clock);
    end
  endtask
  task automatic test_reset;
    iniciar = 1'b1;
    a = 8'd3;
    b = 8'd4;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++; if (produto !== 16'd0) begin fails++; $display("FAIL reset_produto got %h want 0000", produto); end
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    tests++; if (pronto !== 1'b0) begin fails++; $display("FAIL reset_pronto got %b want 0", pronto); end
    reset = 1'b0;
    iniciar = 1'b0;
    @(negedge clock);
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL idle_ocupado got %b want 0", ocupado); end
  endtask
  task automatic test_op(input string nm, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] want, input bit glitch);
    int n_occ, pr_at, pr_cnt;
    logic [15:0] val;
    start(x, y);
    observe(glitch, n_occ, pr_at, pr_cnt, val);
    tests++; if (val !== want) begin fails++; $display("FAIL %s_produto got %h want %h", nm, val, want); end
    tests++; if (n_occ != 9) begin fails++; $display("FAIL %s_ocupado_cycles got %0d want 9", nm, n_occ); end
    tests++; if (pr_cnt != 1) begin fails++; $display("FAIL %s_pronto_pulses got %0d want 1", nm, pr_cnt); end
    tests++; if (pr_at != 8) begin fails++; $display("FAIL %s_latency got %0d want 8", nm, pr_at); end
    tests++; if (produto !== want) begin fails++; $display("FAIL %s_hold got %h want %h", nm, produto, want); end
  endtask
  task automatic test_abort;
    int n_pr;
    start(8'hC3, 8'h5A);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL abort_ocupado got %b want 0", ocupado); end
    tests++; if (produto !== 16'd0) begin fails++; $display("FAIL abort_produto got %h want 0000", produto); end
    n_pr = 0;
    for (int i = 0; i < 12; i++) begin
      if (pronto) n_pr++;
      @(negedge clock);
    end
    tests++; if (n_pr != 0) begin fails++; $display("FAIL abort_pronto got %0d pulses want 0", n_pr); end
    test_op("after_abort", 8'h5A, 8'hC3, 16'h448E, 1'b0);
  endtask
  task automatic test_back_to_back;
    logic [7:0] bl [6];
    logic [7:0] ea, eb;
    logic [15:0] e;
    int j, gap;
    bl = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h5B};
    j = 0;
    gap = 0;
    ea = 8'd0;
    eb = bl[0];
    a = ea;
    b = eb;
    iniciar = 1'b1;
    while (j < 1536) begin
      @(negedge clock);
      gap++;
      if (gap > 30) begin
        tests++; fails++;
        $display("FAIL sweep_timeout op %0d got no pronto within 30 cycles want one", j);
        break;
      end
      if (pronto) begin
        e = ea * eb;
        tests++; if (produto !== e) begin fails++; $display("FAIL sweep_produto %h*%h got %h want %h", ea, eb, produto, e); end
        if (j > 0) begin
          tests++; if (gap != 10) begin fails++; $display("FAIL sweep_period op %0d got %0d want 10", j, gap); end
        end
        gap = 0;
        j++;
        ea = j[7:0];
        eb = bl[(j / 256) % 6];
        a = ea;
        b = eb;
      end
    end
    iniciar = 1'b0;
    repeat (12) @(negedge clock);
  endtask
  initial begin
    @(negedge clock);
    test_reset;
    test_op("basic", 8'd13, 8'd11, 16'd143, 1'b0);
    test_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    test_op("zero_a", 8'h00, 8'hA5, 16'h0000, 1'b0);
    test_op("zero_b", 8'hA5, 8'h00, 16'h0000, 1'b0);
    test_op("ignore", 8'd200, 8'd3, 16'd600, 1'b1);
    test_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
